// File: rtl/rf_wb_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rf_wb_arbiter_if : requester handshake plus register-file write port     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface rf_wb_arbiter_if #(
   parameter int NREQ = 3,
   parameter int XLEN = 32,
   parameter int AW   = 5
);
   logic [NREQ-1:0]      req_valid;
   logic [NREQ-1:0]      req_ready;
   logic [NREQ*AW-1:0]   req_rd;
   logic [NREQ*XLEN-1:0] req_data;
   logic                 wr_en;
   logic [AW-1:0]        wr_rd;
   logic [XLEN-1:0]      wr_data;

   modport master (
      output req_valid, req_rd, req_data,
      input  req_ready, wr_en, wr_rd, wr_data
   );

   modport slave (
      input  req_valid, req_rd, req_data,
      output req_ready, wr_en, wr_rd, wr_data
   );
endinterface
`default_nettype wire

// File: rtl/rf_wb_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rf_wb_arbiter : round-robin write-back scheduler for the register file,  |
// | optional write-to-read bypass under RF_WB_BYPASS_EN. Rev 1.0             |
// +--------------------------------------------------------------------------+
module rf_wb_arbiter #(
   parameter int NREQ = 3,
   parameter int XLEN = 32,
   parameter int AW   = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              stall,
   rf_wb_arbiter_if.slave    bus,
   input  logic [AW-1:0]     rs1,
   input  logic [AW-1:0]     rs2,
   input  logic [XLEN-1:0]   rf_rs1,
   input  logic [XLEN-1:0]   rf_rs2,
   output logic [XLEN-1:0]   fwd_rs1,
   output logic [XLEN-1:0]   fwd_rs2,
   output logic [15:0]       drop_cnt
);
   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [PW-1:0]   r_ptr;
   logic            r_wr_en;
   logic [AW-1:0]   r_wr_rd;
   logic [XLEN-1:0] r_wr_data;
   logic [15:0]     r_drop;

   logic            w_found;
   logic            w_xfer;
   logic [PW-1:0]   w_gnt;
   logic [AW-1:0]   w_sel_rd;
   logic [XLEN-1:0] w_sel_data;

   function automatic logic [PW-1:0] wrap_idx(input logic [PW-1:0] base, input int k);
      int s;
      s = int'(base) + k;
      if (s >= NREQ) s = s - NREQ;
      return PW'(s);
   endfunction

   // Scan downward so the requester closest to the pointer is the last, winning, hit.
   always_comb begin
      w_found = 1'b0;
      w_gnt   = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (bus.req_valid[wrap_idx(r_ptr, k)]) begin
            w_found = 1'b1;
            w_gnt   = wrap_idx(r_ptr, k);
         end
      end
   end

   // Gating with rst_n keeps ready low for the whole asynchronous reset.
   assign w_xfer     = w_found & ~stall & rst_n;
   assign w_sel_rd   = bus.req_rd[w_gnt*AW +: AW];
   assign w_sel_data = bus.req_data[w_gnt*XLEN +: XLEN];

   always_comb begin
      bus.req_ready = '0;
      for (int i = 0; i < NREQ; i++) begin
         bus.req_ready[i] = w_xfer && (w_gnt == PW'(i));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr     <= '0;
         r_wr_en   <= 1'b0;
         r_wr_rd   <= '0;
         r_wr_data <= '0;
         r_drop    <= '0;
      end else if (w_xfer) begin
         r_ptr     <= wrap_idx(w_gnt, 1);
         r_wr_en   <= (w_sel_rd != '0);
         r_wr_rd   <= w_sel_rd;
         r_wr_data <= w_sel_data;
         if (w_sel_rd == '0 && r_drop != 16'hFFFF) begin
            r_drop <= r_drop + 16'd1;
         end
      end else begin
         r_wr_en   <= 1'b0;
      end
   end

   assign bus.wr_en   = r_wr_en;
   assign bus.wr_rd   = r_wr_rd;
   assign bus.wr_data = r_wr_data;
   assign drop_cnt    = r_drop;

`ifdef RF_WB_BYPASS_EN
   assign fwd_rs1 = (r_wr_en && r_wr_rd == rs1 && rs1 != '0) ? r_wr_data : rf_rs1;
   assign fwd_rs2 = (r_wr_en && r_wr_rd == rs2 && rs2 != '0) ? r_wr_data : rf_rs2;
`else
   logic w_unused_rs;
   assign w_unused_rs = ^{rs1, rs2};
   assign fwd_rs1     = rf_rs1;
   assign fwd_rs2     = rf_rs2;
`endif
endmodule
`default_nettype wire
